// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter: two-initiator Wishbone round-robin arbiter in front of the SoC SRAM slave.
// The grant is held for as long as the owning initiator keeps CYC high. At least one IDLE
// cycle separates two grants. The slave-side signals and the return paths are a combinational
// mux of the granted initiator and are forced to zero while IDLE.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to end stalled strobes after TIMEOUT_CYCLES.
// Ports:
//   wb_clk_i, wb_rst_n_i           clock, async active-low reset
//   m0_wb_*, m1_wb_*               initiator ports (cyc/stb/adr/sel/we/dat in; dat/ack/err out)
//   s_wb_*                         SRAM slave port
//   gnt_o                          one-hot current grant (bit0 = initiator 0)
module wb_sram_arbiter #(
  parameter int unsigned ADR_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 m0_wb_cyc_i,
  input  logic                 m0_wb_stb_i,
  input  logic [ADR_WIDTH-1:0] m0_wb_adr_i,
  input  logic [3:0]           m0_wb_sel_i,
  input  logic                 m0_wb_we_i,
  input  logic [31:0]          m0_wb_dat_i,
  output logic [31:0]          m0_wb_dat_o,
  output logic                 m0_wb_ack_o,
  output logic                 m0_wb_err_o,
  input  logic                 m1_wb_cyc_i,
  input  logic                 m1_wb_stb_i,
  input  logic [ADR_WIDTH-1:0] m1_wb_adr_i,
  input  logic [3:0]           m1_wb_sel_i,
  input  logic                 m1_wb_we_i,
  input  logic [31:0]          m1_wb_dat_i,
  output logic [31:0]          m1_wb_dat_o,
  output logic                 m1_wb_ack_o,
  output logic                 m1_wb_err_o,
  output logic                 s_wb_cyc_o,
  output logic                 s_wb_stb_o,
  output logic                 s_wb_we_o,
  output logic [ADR_WIDTH-1:0] s_wb_adr_o,
  output logic [3:0]           s_wb_sel_o,
  output logic [31:0]          s_wb_dat_o,
  input  logic [31:0]          s_wb_dat_i,
  input  logic                 s_wb_ack_i,
  input  logic                 s_wb_err_i,
  output logic [1:0]           gnt_o
);

  // Elaboration-time guard on the watchdog limit.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_sram_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GNT0 = 2'd1, ST_GNT1 = 2'd2} state_t;

  state_t r_state, w_state_nxt;
  logic   r_last, w_last_nxt;   // last initiator served; the other one wins a tie
  logic   w_sel0, w_sel1;
  logic   w_stb_raw;
  logic   w_timeout;

  // State register; reset drops the grant, and with it the slave CYC/STB, asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: round-robin on contention, grant locked while the owner holds CYC.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        else if (m0_wb_cyc_i)           w_state_nxt = ST_GNT0;
        else if (m1_wb_cyc_i)           w_state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0_wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!m1_wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sel0 = (r_state == ST_GNT0);
  assign w_sel1 = (r_state == ST_GNT1);
  assign gnt_o  = {w_sel1, w_sel0};

  assign w_stb_raw = (w_sel0 & m0_wb_stb_i) | (w_sel1 & m1_wb_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_stall;

  // A stalled cycle is a strobe with no termination; an ack in the limit cycle beats the timeout.
  assign w_stall   = w_stb_raw & ~s_wb_ack_i & ~s_wb_err_i;
  assign w_timeout = w_stall & (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog; IDLE always separates grants and has no strobe, so a grant change also clears it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)               r_wdog <= '0;
    else if (!w_stall || w_timeout) r_wdog <= '0;
    else                           r_wdog <= r_wdog + WD_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Slave-side mux; all zero while IDLE, strobe masked in the timeout cycle.
  always_comb begin
    s_wb_cyc_o = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_adr_o = '0;
    s_wb_sel_o = '0;
    s_wb_dat_o = '0;
    if (w_sel0) begin
      s_wb_cyc_o = m0_wb_cyc_i;
      s_wb_we_o  = m0_wb_we_i;
      s_wb_adr_o = m0_wb_adr_i;
      s_wb_sel_o = m0_wb_sel_i;
      s_wb_dat_o = m0_wb_dat_i;
    end else if (w_sel1) begin
      s_wb_cyc_o = m1_wb_cyc_i;
      s_wb_we_o  = m1_wb_we_i;
      s_wb_adr_o = m1_wb_adr_i;
      s_wb_sel_o = m1_wb_sel_i;
      s_wb_dat_o = m1_wb_dat_i;
    end
  end

  assign s_wb_stb_o = w_stb_raw & ~w_timeout;

  // Return paths only to the granted initiator; terminations during IDLE are dropped.
  assign m0_wb_dat_o = w_sel0 ? s_wb_dat_i : 32'h0;
  assign m0_wb_ack_o = w_sel0 & s_wb_ack_i;
  assign m0_wb_err_o = w_sel0 & (s_wb_err_i | w_timeout);
  assign m1_wb_dat_o = w_sel1 ? s_wb_dat_i : 32'h0;
  assign m1_wb_ack_o = w_sel1 & s_wb_ack_i;
  assign m1_wb_err_o = w_sel1 & (s_wb_err_i | w_timeout);

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: directed scenarios plus randomized traffic, all compared
// against an owner/last-served reference model kept here.
module tb_wb_sram_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [3:0]  sel [2];
  logic [31:0] mdat [2];
  logic        mack [2];
  logic        merr [2];
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [1:0]  gnt;

  int n_vec = 0;
  int n_err = 0;
  int own;     // -1 idle, else granted initiator
  int last;    // last initiator served
  int wd;      // consecutive stalled cycles

  always #5 clk = ~clk;

  wb_sram_arbiter #(.ADR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_wb_cyc_i(cyc[0]), .m0_wb_stb_i(stb[0]), .m0_wb_adr_i(adr[0]), .m0_wb_sel_i(sel[0]),
    .m0_wb_we_i(we[0]), .m0_wb_dat_i(dat[0]), .m0_wb_dat_o(mdat[0]), .m0_wb_ack_o(mack[0]),
    .m0_wb_err_o(merr[0]),
    .m1_wb_cyc_i(cyc[1]), .m1_wb_stb_i(stb[1]), .m1_wb_adr_i(adr[1]), .m1_wb_sel_i(sel[1]),
    .m1_wb_we_i(we[1]), .m1_wb_dat_i(dat[1]), .m1_wb_dat_o(mdat[1]), .m1_wb_ack_o(mack[1]),
    .m1_wb_err_o(merr[1]),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_adr_o(s_adr),
    .s_wb_sel_o(s_sel), .s_wb_dat_o(s_dat_o), .s_wb_dat_i(s_dat_i),
    .s_wb_ack_i(s_ack), .s_wb_err_i(s_err), .gnt_o(gnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mdl_timeout();
`ifdef WB_ARB_TIMEOUT_EN
    if (own < 0) return 1'b0;
    return stb[own] && !s_ack && !s_err && (wd == int'(TO) - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Model update at a clock edge, using the inputs present at that edge.
  task automatic model_edge();
    if (own >= 0 && stb[own] && !s_ack && !s_err) begin
      if (wd == int'(TO) - 1) wd = 0;
      else wd = wd + 1;
    end else begin
      wd = 0;
    end
    if (own < 0) begin
      if (cyc[0] && cyc[1]) own = (last == 1) ? 0 : 1;
      else if (cyc[0])      own = 0;
      else if (cyc[1])      own = 1;
    end else if (!cyc[own]) begin
      last = own;
      own  = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #2;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic chk();
    bit to;
    logic [1:0] eg;
    #1;
    to = mdl_timeout();
    eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    check("gnt", 32'(gnt), 32'(eg));
    if (own < 0) begin
      check("s_cyc", 32'(s_cyc), 0);
      check("s_stb", 32'(s_stb), 0);
      check("s_we",  32'(s_we), 0);
      check("s_adr", s_adr, 0);
      check("s_sel", 32'(s_sel), 0);
      check("s_dat", s_dat_o, 0);
    end else begin
      check("s_cyc", 32'(s_cyc), 32'(cyc[own]));
      check("s_stb", 32'(s_stb), 32'(stb[own] & ~to));
      check("s_we",  32'(s_we), 32'(we[own]));
      check("s_adr", s_adr, adr[own]);
      check("s_sel", 32'(s_sel), 32'(sel[own]));
      check("s_dat", s_dat_o, dat[own]);
    end
    for (int i = 0; i < 2; i++) begin
      check("m_ack", 32'(mack[i]), (own == i) ? 32'(s_ack) : 0);
      check("m_err", 32'(merr[i]), (own == i) ? 32'(s_err | to) : 0);
      check("m_dat", mdat[i], (own == i) ? s_dat_i : 0);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; dat[i] = 0; sel[i] = 0;
    end
    s_dat_i = 0; s_ack = 0; s_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    own = -1; last = 1; wd = 0;
    chk();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "bench time limit");
  end

  initial begin
    int errs;
    int w;
    clear_inputs();
    own = -1; last = 1; wd = 0;

    // 1: single read by m0, one-cycle ack.
    do_reset();
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h0000_0010; sel[0] = 4'hF;
    chk();
    check("t1_req_gnt", 32'(gnt), 0);
    check("t1_req_cyc", 32'(s_cyc), 0);
    tick();
    s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
    chk();
    check("t1_gnt", 32'(gnt), 1);
    check("t1_adr", s_adr, 32'h10);
    check("t1_ack", 32'(mack[0]), 1);
    check("t1_dat", mdat[0], 32'hDEAD_BEEF);
    tick();
    cyc[0] = 0; stb[0] = 0; s_ack = 0;
    chk();
    tick();
    chk();
    check("t1_rel_gnt", 32'(gnt), 0);

    // 2: simultaneous requests after reset: m0 first, IDLE gap, then m1.
    do_reset();
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; we[1] = 1;
    chk();
    tick(); chk();
    check("t2_first", 32'(gnt), 1);
    tick(); cyc[0] = 0; stb[0] = 0; chk();
    tick(); chk();
    check("t2_gap", 32'(gnt), 0);
    check("t2_gap_cyc", 32'(s_cyc), 0);
    tick(); chk();
    check("t2_second", 32'(gnt), 2);

    // 3: m1 holds the bus over 4 write beats while m0 waits.
    cyc[0] = 1; stb[0] = 1;
    for (int b = 0; b < 4; b++) begin
      tick();
      adr[1] = 32'h100 + 32'(b * 4); dat[1] = $urandom; sel[1] = 4'hF; s_ack = 1;
      chk();
      check("t3_lock", 32'(gnt), 2);
      check("t3_m0_ack", 32'(mack[0]), 0);
      check("t3_m0_err", 32'(merr[0]), 0);
    end
    tick(); cyc[1] = 0; stb[1] = 0; s_ack = 0; chk();
    tick(); chk();
    tick(); chk();
    check("t3_m0_gnt", 32'(gnt), 1);

    // 4: back-to-back contention, grants alternate.
    cyc[1] = 1; stb[1] = 1;
    w = 0;
    for (int r = 0; r < 8; r++) begin
      tick(); cyc[w] = 0; stb[w] = 0; chk();
      tick(); cyc[w] = 1; stb[w] = 1; chk();
      check("t4_idle_cyc", 32'(s_cyc), 0);
      tick(); chk();
      w = 1 - w;
      check("t4_alt", 32'(gnt), (w == 0) ? 1 : 2);
    end

    // 5a: slave never acks for 1000 cycles.
    do_reset();
    cyc[0] = 1; stb[0] = 1;
    tick();
    errs = 0;
    for (int k = 0; k < 1000; k++) begin
      chk();
      if (merr[0]) errs++;
      tick();
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("t5_err_count", 32'(errs), 32'(1000 / TO));
`else
    check("t5_err_count", 32'(errs), 0);
`endif

    // 5b: ack in the would-be timeout cycle wins.
    do_reset();
    cyc[0] = 1; stb[0] = 1;
    for (int k = 0; k < 3; k++) begin tick(); chk(); end
    tick(); s_ack = 1; chk();
    check("t5_ack_wins", 32'(mack[0]), 1);
    check("t5_no_err", 32'(merr[0]), 0);

    // 6: async reset during an m1 write.
    do_reset();
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h40; dat[1] = 32'h1234_5678; sel[1] = 4'h3;
    tick(); chk();
    tick(); s_ack = 1; chk();
    check("t6_pre_ack", 32'(mack[1]), 1);
    #1 rst_n = 1'b0;
    own = -1; last = 1; wd = 0;
    #1;
    check("t6_cyc", 32'(s_cyc), 0);
    check("t6_stb", 32'(s_stb), 0);
    check("t6_gnt", 32'(gnt), 0);
    check("t6_ack", 32'(mack[1]), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) cyc[i] = ~cyc[i];
        stb[i] = cyc[i] & 1'($urandom);
        we[i]  = 1'($urandom);
        adr[i] = $urandom; dat[i] = $urandom; sel[i] = 4'($urandom);
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = !s_ack && ($urandom_range(0, 9) == 0);
      s_dat_i = $urandom;
      chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
